// File: rtl/fft_ctrl_pkg.sv
// Shared definitions for the radix-2 single-delay-feedback FFT stage sequencer.
//   state_e         : sequencer state (IDLE, RUN, FLUSH)
//   dp_ctrl_t       : per-cycle control bundle for the stage datapath
//                     (delay-line shift, zero feed, butterfly enable, twiddle)
//   beat_cnt_width(): beat counter width for a given delay-line depth
package fft_ctrl_pkg;

  localparam int DEFAULT_DEPTH = 16;

  // Widest twiddle index carried in dp_ctrl_t; supports DEPTH up to 2**16.
  localparam int TW_ADDR_MAX_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

  typedef struct packed {
    logic                     sr_shift_en;
    logic                     zero_in;
    logic                     bfly_en;
    logic                     tw_valid;
    logic [TW_ADDR_MAX_W-1:0] tw_addr;
  } dp_ctrl_t;

  // A frame is 2*depth beats, so the beat counter spans 0..2*depth-1.
  function automatic int beat_cnt_width(input int depth);
    return $clog2(2 * depth);
  endfunction

endpackage

// File: rtl/fft_sdf_stage_ctrl.sv
// Sequencer for one radix-2 SDF FFT stage (delay line + butterfly + twiddle ROM).
// Counts accepted beats of 2*DEPTH-beat frames and drives the datapath controls.
// After an end-of-stream beat it self-generates DEPTH zero-fed flush cycles so
// the last frame's differences drain out of the delay line.
//
// Ports:
//   clk, rst          clock; synchronous active-high reset
//   din_valid         upstream beat valid
//   din_sof, din_eos  start of frame / end of stream, qualified by din_valid
//   in_ready          beat accepted when high; low during FLUSH
//   sr_shift_en       delay-line shift enable            (combinational)
//   zero_in           feed zeros into the delay line     (combinational)
//   bfly_en           butterfly add/sub active           (combinational)
//   tw_addr, tw_valid twiddle index for drained difference (combinational)
//   dout_valid        stage output valid                 (registered)
//   dout_sof          first output of a frame            (registered)
//   frame_cnt         frames fully drained, wraps        (registered)
//   err_sof, err_eos  one-cycle pulses on misaligned sof / eos (registered)
//   busy              state != IDLE or a drain is pending
module fft_sdf_stage_ctrl
  import fft_ctrl_pkg::*;
#(
  parameter int DEPTH  = DEFAULT_DEPTH,
  parameter int CNT_W  = beat_cnt_width(DEPTH),
  parameter int FCNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              din_valid,
  input  logic              din_sof,
  input  logic              din_eos,
  output logic              in_ready,
  output logic              sr_shift_en,
  output logic              zero_in,
  output logic              bfly_en,
  output logic [CNT_W-2:0]  tw_addr,
  output logic              tw_valid,
  output logic              dout_valid,
  output logic              dout_sof,
  output logic [FCNT_W-1:0] frame_cnt,
  output logic              err_sof,
  output logic              err_eos,
  output logic              busy
);

  localparam logic [CNT_W-1:0] BCNT_HALF       = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] BCNT_DRAIN_LAST = CNT_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] BCNT_LAST       = CNT_W'(2 * DEPTH - 1);
  localparam logic [CNT_W-2:0] FCNT_LAST       = '1;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   bcnt_q, bcnt_d;
  logic [CNT_W-2:0]   fcnt_q, fcnt_d;
  logic               pend_q, pend_d;
  logic [FCNT_W-1:0]  frame_cnt_q, frame_cnt_d;
  logic               dout_valid_q, dout_valid_d;
  logic               dout_sof_q, dout_sof_d;
  logic               err_sof_q, err_sof_d;
  logic               err_eos_q, err_eos_d;

  logic     acc;
  logic     flushing;
  logic     first_half;
  dp_ctrl_t dp;
  logic     unused_tw_hi;

  // Datapath controls act on the same cycle as the beat they steer.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    dp           = '0;
    flushing     = (state_q == ST_FLUSH);
    in_ready     = !flushing;
    acc          = din_valid & in_ready;
    // The MSB of the beat counter splits the frame into fill and butterfly halves.
    first_half   = !bcnt_q[CNT_W-1];

    dp.sr_shift_en = acc | flushing;
    dp.zero_in     = flushing;
    dp.bfly_en     = acc & !first_half;
    // First-half beats of a frame drain the previous frame's differences.
    dp.tw_valid    = (acc & first_half & pend_q) | flushing;
    if (flushing) begin
      dp.tw_addr = TW_ADDR_MAX_W'(fcnt_q);
    end else if (acc && first_half) begin
      dp.tw_addr = TW_ADDR_MAX_W'(bcnt_q[CNT_W-2:0]);
    end

    unused_tw_hi = ^dp.tw_addr[TW_ADDR_MAX_W-1:CNT_W-1];
  end

  assign sr_shift_en = dp.sr_shift_en;
  assign zero_in     = dp.zero_in;
  assign bfly_en     = dp.bfly_en;
  assign tw_valid    = dp.tw_valid;
  assign tw_addr     = dp.tw_addr[CNT_W-2:0];
  assign busy        = (state_q != ST_IDLE) | pend_q;

  // Next-state logic for the sequencer and its registered outputs.
  always_comb begin
    state_d      = state_q;
    bcnt_d       = bcnt_q;
    fcnt_d       = fcnt_q;
    pend_d       = pend_q;
    frame_cnt_d  = frame_cnt_q;
    err_sof_d    = 1'b0;
    err_eos_d    = 1'b0;
    dout_valid_d = dp.bfly_en | dp.tw_valid;
    dout_sof_d   = acc & (bcnt_q == BCNT_HALF);

    unique case (state_q)
      ST_IDLE: begin
        if (acc) begin
          if (din_sof) begin
            state_d = ST_RUN;
            bcnt_d  = CNT_W'(1);
          end else begin
            err_sof_d = 1'b1;
          end
          err_eos_d = din_eos;
        end
      end

      ST_RUN: begin
        if (acc) begin
          if (din_sof && bcnt_q != '0) begin
            // Misaligned sof restarts the frame; the half-drained frame is
            // abandoned and not counted.
            err_sof_d = 1'b1;
            err_eos_d = din_eos;
            bcnt_d    = CNT_W'(1);
            pend_d    = 1'b0;
          end else begin
            err_sof_d = !din_sof && (bcnt_q == '0);
            // Frame length is a power of two, so the increment wraps 2*DEPTH-1 to 0.
            bcnt_d    = bcnt_q + CNT_W'(1);
            if (bcnt_q == BCNT_DRAIN_LAST && pend_q) begin
              pend_d      = 1'b0;
              frame_cnt_d = frame_cnt_q + FCNT_W'(1);
            end
            if (bcnt_q == BCNT_LAST) begin
              pend_d = 1'b1;
              if (din_eos) begin
                state_d = ST_FLUSH;
                fcnt_d  = '0;
              end
            end else begin
              err_eos_d = din_eos;
            end
          end
        end
      end

      ST_FLUSH: begin
        fcnt_d = fcnt_q + 1'b1;
        if (fcnt_q == FCNT_LAST) begin
          state_d     = ST_IDLE;
          fcnt_d      = '0;
          pend_d      = 1'b0;
          frame_cnt_d = frame_cnt_q + FCNT_W'(1);
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state_q      <= ST_IDLE;
      bcnt_q       <= '0;
      fcnt_q       <= '0;
      pend_q       <= 1'b0;
      frame_cnt_q  <= '0;
      dout_valid_q <= 1'b0;
      dout_sof_q   <= 1'b0;
      err_sof_q    <= 1'b0;
      err_eos_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      bcnt_q       <= bcnt_d;
      fcnt_q       <= fcnt_d;
      pend_q       <= pend_d;
      frame_cnt_q  <= frame_cnt_d;
      dout_valid_q <= dout_valid_d;
      dout_sof_q   <= dout_sof_d;
      err_sof_q    <= err_sof_d;
      err_eos_q    <= err_eos_d;
    end
  end

  assign dout_valid = dout_valid_q;
  assign dout_sof   = dout_sof_q;
  assign frame_cnt  = frame_cnt_q;
  assign err_sof    = err_sof_q;
  assign err_eos    = err_eos_q;

endmodule

// File: tb/tb_fft_sdf_stage_ctrl.sv
// Self-checking bench for fft_sdf_stage_ctrl (DEPTH=16).
// A behavioural model tracks the frame position, whether a previous frame still
// owes its drain, the flush progress and the drained-frame total; every cycle
// the DUT outputs are compared against it. Scenario tasks add targeted checks.
module tb_fft_sdf_stage_ctrl;

  localparam int DEPTH  = 16;
  localparam int CNT_W  = 5;
  localparam int FCNT_W = 16;
  localparam int FRAME  = 2 * DEPTH;

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_FLUSH = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              din_valid = 1'b0;
  logic              din_sof = 1'b0;
  logic              din_eos = 1'b0;
  logic              in_ready;
  logic              sr_shift_en;
  logic              zero_in;
  logic              bfly_en;
  logic [CNT_W-2:0]  tw_addr;
  logic              tw_valid;
  logic              dout_valid;
  logic              dout_sof;
  logic [FCNT_W-1:0] frame_cnt;
  logic              err_sof;
  logic              err_eos;
  logic              busy;

  fft_sdf_stage_ctrl #(.DEPTH(DEPTH), .CNT_W(CNT_W), .FCNT_W(FCNT_W)) dut (
    .clk(clk), .rst(rst),
    .din_valid(din_valid), .din_sof(din_sof), .din_eos(din_eos),
    .in_ready(in_ready), .sr_shift_en(sr_shift_en), .zero_in(zero_in),
    .bfly_en(bfly_en), .tw_addr(tw_addr), .tw_valid(tw_valid),
    .dout_valid(dout_valid), .dout_sof(dout_sof), .frame_cnt(frame_cnt),
    .err_sof(err_sof), .err_eos(err_eos), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Behavioural model state
  int m_mode, m_pos, m_flush_n, m_frames;
  bit m_owed;

  // Observed-event statistics for scenario checks
  int dv_total, dv_run, dv_run_max, dsof_total, esof_total, eeos_total, zero_total, bfly_total;

  task automatic clear_stats();
    dv_total = 0; dv_run = 0; dv_run_max = 0; dsof_total = 0;
    esof_total = 0; eeos_total = 0; zero_total = 0; bfly_total = 0;
  endtask

  task automatic model_reset();
    m_mode = M_IDLE; m_pos = 0; m_flush_n = 0; m_frames = 0; m_owed = 0;
  endtask

  // Entered and left at a falling edge.
  task automatic do_reset();
    rst = 1'b1; din_valid = 1'b0; din_sof = 1'b0; din_eos = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  // One clock cycle: drive inputs, compare same-cycle controls, advance the
  // model across the edge and compare the registered outputs.
  task automatic step(input logic v, input logic s, input logic e);
    logic fl, a, second, x_ready, x_shift, x_zero, x_bfly, x_twv;
    logic x_dv, x_dsof, x_esof, x_eeos, x_busy;
    logic [CNT_W-2:0] x_twa;
    din_valid = v; din_sof = s; din_eos = e;
    #1;
    fl      = (m_mode == M_FLUSH);
    x_ready = !fl;
    a       = v && x_ready;
    second  = (m_pos >= DEPTH);
    x_shift = a || fl;
    x_zero  = fl;
    x_bfly  = a && second;
    x_twv   = (a && !second && m_owed) || fl;
    x_twa   = fl ? (CNT_W-1)'(m_flush_n) : (a && !second) ? (CNT_W-1)'(m_pos) : '0;

    n_cmp++; if (in_ready !== x_ready) begin n_bad++; $display("FAIL in_ready: got %b want %b t=%0t", in_ready, x_ready, $time); end
    n_cmp++; if (sr_shift_en !== x_shift) begin n_bad++; $display("FAIL sr_shift_en: got %b want %b t=%0t", sr_shift_en, x_shift, $time); end
    n_cmp++; if (zero_in !== x_zero) begin n_bad++; $display("FAIL zero_in: got %b want %b t=%0t", zero_in, x_zero, $time); end
    n_cmp++; if (bfly_en !== x_bfly) begin n_bad++; $display("FAIL bfly_en: got %b want %b t=%0t", bfly_en, x_bfly, $time); end
    n_cmp++; if (tw_valid !== x_twv) begin n_bad++; $display("FAIL tw_valid: got %b want %b t=%0t", tw_valid, x_twv, $time); end
    n_cmp++; if (tw_addr !== x_twa) begin n_bad++; $display("FAIL tw_addr: got %0d want %0d t=%0t", tw_addr, x_twa, $time); end
    if (zero_in === 1'b1) zero_total++;
    if (bfly_en === 1'b1) bfly_total++;

    // Registered expectations from the rules, using pre-edge model state
    x_dv   = x_bfly || x_twv;
    x_dsof = a && (m_pos == DEPTH);
    x_esof = a && (s ? (m_pos != 0) : (m_pos == 0));
    x_eeos = a && e && !(m_mode == M_RUN && m_pos == FRAME - 1 && !s);

    // Advance the model
    if (fl) begin
      m_flush_n++;
      if (m_flush_n == DEPTH) begin
        m_mode = M_IDLE; m_flush_n = 0; m_owed = 0; m_frames = (m_frames + 1) % 65536;
      end
    end else if (a) begin
      if (m_mode == M_IDLE) begin
        if (s) begin m_mode = M_RUN; m_pos = 1; end
      end else if (s && m_pos != 0) begin
        m_pos = 1; m_owed = 0;
      end else begin
        if (m_pos == DEPTH - 1 && m_owed) begin
          m_owed = 0; m_frames = (m_frames + 1) % 65536;
        end
        if (m_pos == FRAME - 1) begin
          m_pos = 0; m_owed = 1;
          if (e) begin m_mode = M_FLUSH; m_flush_n = 0; end
        end else begin
          m_pos++;
        end
      end
    end
    x_busy = (m_mode != M_IDLE) || m_owed;

    @(posedge clk);
    @(negedge clk);
    n_cmp++; if (dout_valid !== x_dv) begin n_bad++; $display("FAIL dout_valid: got %b want %b t=%0t", dout_valid, x_dv, $time); end
    n_cmp++; if (dout_sof !== x_dsof) begin n_bad++; $display("FAIL dout_sof: got %b want %b t=%0t", dout_sof, x_dsof, $time); end
    n_cmp++; if (err_sof !== x_esof) begin n_bad++; $display("FAIL err_sof: got %b want %b t=%0t", err_sof, x_esof, $time); end
    n_cmp++; if (err_eos !== x_eeos) begin n_bad++; $display("FAIL err_eos: got %b want %b t=%0t", err_eos, x_eeos, $time); end
    n_cmp++; if (frame_cnt !== FCNT_W'(m_frames)) begin n_bad++; $display("FAIL frame_cnt: got %0d want %0d t=%0t", frame_cnt, m_frames, $time); end
    n_cmp++; if (busy !== x_busy) begin n_bad++; $display("FAIL busy: got %b want %b t=%0t", busy, x_busy, $time); end

    if (dout_valid === 1'b1) begin
      dv_total++; dv_run++;
      if (dv_run > dv_run_max) dv_run_max = dv_run;
    end else begin
      dv_run = 0;
    end
    if (dout_sof === 1'b1) dsof_total++;
    if (err_sof === 1'b1) esof_total++;
    if (err_eos === 1'b1) eeos_total++;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0);
  endtask

  task automatic send_frames(input int nframes);
    for (int b = 0; b < nframes * FRAME; b++)
      step(1'b1, (b % FRAME) == 0, b == nframes * FRAME - 1);
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    n_cmp++; if (dout_valid !== 1'b0 || dout_sof !== 1'b0) begin n_bad++; $display("FAIL reset_dout: got %b%b want 00", dout_valid, dout_sof); end
    n_cmp++; if (frame_cnt !== '0) begin n_bad++; $display("FAIL reset_frame_cnt: got %0d want 0", frame_cnt); end
    n_cmp++; if (busy !== 1'b0 || err_sof !== 1'b0 || err_eos !== 1'b0) begin n_bad++; $display("FAIL reset_flags: got busy=%b esof=%b eeos=%b want 000", busy, err_sof, err_eos); end
    n_cmp++; if (sr_shift_en !== 1'b0 || zero_in !== 1'b0 || bfly_en !== 1'b0 || tw_valid !== 1'b0 || tw_addr !== '0) begin n_bad++; $display("FAIL reset_ctrl: got %b%b%b%b addr=%0d want 0000 addr=0", sr_shift_en, zero_in, bfly_en, tw_valid, tw_addr); end
    @(negedge clk);
  endtask

  task automatic test_single_frame();
    do_reset(); clear_stats();
    send_frames(1);
    idle_cycles(24);
    n_cmp++; if (bfly_total != DEPTH) begin n_bad++; $display("FAIL single_bfly_count: got %0d want %0d", bfly_total, DEPTH); end
    n_cmp++; if (zero_total != DEPTH) begin n_bad++; $display("FAIL single_flush_len: got %0d want %0d", zero_total, DEPTH); end
    n_cmp++; if (dv_total != FRAME || dv_run_max != FRAME) begin n_bad++; $display("FAIL single_dout_valid: got total=%0d run=%0d want %0d", dv_total, dv_run_max, FRAME); end
    n_cmp++; if (dsof_total != 1) begin n_bad++; $display("FAIL single_dout_sof: got %0d want 1", dsof_total); end
    n_cmp++; if (frame_cnt !== 16'd1 || busy !== 1'b0) begin n_bad++; $display("FAIL single_done: got frame_cnt=%0d busy=%b want 1 0", frame_cnt, busy); end
  endtask

  task automatic test_back_to_back();
    do_reset(); clear_stats();
    send_frames(2);
    idle_cycles(24);
    n_cmp++; if (dv_total != 2 * FRAME || dv_run_max != 2 * FRAME) begin n_bad++; $display("FAIL b2b_dout_valid: got total=%0d run=%0d want %0d", dv_total, dv_run_max, 2 * FRAME); end
    n_cmp++; if (frame_cnt !== 16'd2) begin n_bad++; $display("FAIL b2b_frame_cnt: got %0d want 2", frame_cnt); end
    n_cmp++; if (dsof_total != 2) begin n_bad++; $display("FAIL b2b_dout_sof: got %0d want 2", dsof_total); end
  endtask

  task automatic test_gapped();
    do_reset(); clear_stats();
    for (int b = 0; b < FRAME; b++) begin
      step(1'b1, b == 0, b == FRAME - 1);
      if (b != FRAME - 1) step(1'b0, 1'b1, 1'b1);  // unqualified sof/eos during gaps
    end
    idle_cycles(24);
    n_cmp++; if (dv_total != FRAME) begin n_bad++; $display("FAIL gapped_dout_valid: got %0d want %0d", dv_total, FRAME); end
    n_cmp++; if (esof_total != 0 || eeos_total != 0) begin n_bad++; $display("FAIL gapped_errors: got esof=%0d eeos=%0d want 0 0", esof_total, eeos_total); end
    n_cmp++; if (frame_cnt !== 16'd1) begin n_bad++; $display("FAIL gapped_frame_cnt: got %0d want 1", frame_cnt); end
  endtask

  task automatic test_misaligned_sof();
    do_reset(); clear_stats();
    for (int b = 0; b < 7; b++) step(1'b1, b == 0, 1'b0);
    step(1'b1, 1'b1, 1'b0);  // sof at beat count 7
    n_cmp++; if (esof_total != 1 || frame_cnt !== 16'd0) begin n_bad++; $display("FAIL missof_pulse: got esof=%0d frame_cnt=%0d want 1 0", esof_total, frame_cnt); end
    for (int b = 1; b < FRAME; b++) step(1'b1, 1'b0, b == FRAME - 1);
    idle_cycles(24);
    n_cmp++; if (esof_total != 1 || dsof_total != 1) begin n_bad++; $display("FAIL missof_resync: got esof=%0d dsof=%0d want 1 1", esof_total, dsof_total); end
    n_cmp++; if (frame_cnt !== 16'd1) begin n_bad++; $display("FAIL missof_frame_cnt: got %0d want 1", frame_cnt); end
  endtask

  task automatic test_eos_alignment();
    do_reset(); clear_stats();
    for (int b = 0; b < FRAME; b++) begin
      step(1'b1, b == 0, b == 20 || b == FRAME - 1);
      if (b == 20) begin
        n_cmp++; if (eeos_total != 1 || in_ready !== 1'b1) begin n_bad++; $display("FAIL eos_early: got eeos=%0d in_ready=%b want 1 1", eeos_total, in_ready); end
      end
    end
    n_cmp++; if (in_ready !== 1'b0 || eeos_total != 1) begin n_bad++; $display("FAIL eos_flush_entry: got in_ready=%b eeos=%0d want 0 1", in_ready, eeos_total); end
    idle_cycles(24);
  endtask

  task automatic test_flush_reset();
    do_reset(); clear_stats();
    send_frames(1);
    idle_cycles(5);  // five flush cycles done
    do_reset(); clear_stats();
    #1;
    n_cmp++; if (in_ready !== 1'b1 || dout_valid !== 1'b0) begin n_bad++; $display("FAIL rst_flush_out: got in_ready=%b dout_valid=%b want 1 0", in_ready, dout_valid); end
    n_cmp++; if (frame_cnt !== '0 || busy !== 1'b0) begin n_bad++; $display("FAIL rst_flush_state: got frame_cnt=%0d busy=%b want 0 0", frame_cnt, busy); end
    @(negedge clk);
    idle_cycles(20);
    n_cmp++; if (dv_total != 0) begin n_bad++; $display("FAIL rst_flush_quiet: got %0d outputs want 0", dv_total); end
  endtask

  task automatic test_random();
    logic v, s, e;
    do_reset(); clear_stats();
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 999) == 0) begin
        do_reset();
      end else if ($urandom_range(0, 3) == 0 || m_mode == M_FLUSH) begin
        step(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end else begin
        v = 1'b1;
        s = (m_pos == 0);
        e = (m_pos == FRAME - 1) && ($urandom_range(0, 2) == 0);
        if ($urandom_range(0, 50) == 0) s = ~s;
        if ($urandom_range(0, 50) == 0) e = 1'b1;
        step(v, s, e);
      end
    end
  endtask

  initial begin
    model_reset();
    clear_stats();
    @(negedge clk);
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_gapped();
    test_misaligned_sof();
    test_eos_alignment();
    test_flush_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
